activation_unit: RTL and testbench



---
 rtl/activation_pkg.sv | 44 ++++
 rtl/activation_lane.sv | 71 +++++++
 rtl/activation_unit.sv | 53 +++++
 tb/tb_activation_unit.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/activation_pkg.sv
// rtl/activation_pkg.sv - shared select encoding and PLAN constants
// Contents:
//   act_sel_e          - per-cycle activation function select
//   plan_* functions   - PLAN breakpoints/offsets as integers scaled by ONE = 2^s
package activation_pkg;

  typedef enum logic [1:0] {
    ACT_NONE    = 2'b00,
    ACT_RELU    = 2'b01,
    ACT_SIGMOID = 2'b10,
    ACT_TANH    = 2'b11
  } act_sel_e;

  // 1.0 in fixed point.
  function automatic int plan_one(input int s);
    return 1 << s;
  endfunction

  // 5.0: saturation breakpoint.
  function automatic int plan_bp_hi(input int s);
    return 5 << s;
  endfunction

  // 2.375 = 19/8.
  function automatic int plan_bp_mid(input int s);
    return (19 << s) >> 3;
  endfunction

  // 0.84375 = 27/32.
  function automatic int plan_off_hi(input int s);
    return (27 << s) >> 5;
  endfunction

  // 0.625 = 5/8.
  function automatic int plan_off_mid(input int s);
    return (5 << s) >> 3;
  endfunction

  // 0.5.
  function automatic int plan_off_lo(input int s);
    return 1 << (s - 1);
  endfunction

endpackage

// File: rtl/activation_lane.sv
// rtl/activation_lane.sv - combinational single-lane activation function
// Ports:
//   x   - signed lane input, DATA_WIDTH bits, S fractional bits
//   sel - function select (identity / ReLU / sigmoid / tanh)
//   y   - signed lane result, same format as x
module activation_lane
  import activation_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int S          = 7
) (
  input  logic signed [DATA_WIDTH-1:0] x,
  input  act_sel_e                     sel,
  output logic signed [DATA_WIDTH-1:0] y
);

  localparam logic [DATA_WIDTH-1:0] ONE     = DATA_WIDTH'(plan_one(S));
  localparam logic [DATA_WIDTH-1:0] BP_HI   = DATA_WIDTH'(plan_bp_hi(S));
  localparam logic [DATA_WIDTH-1:0] BP_MID  = DATA_WIDTH'(plan_bp_mid(S));
  localparam logic [DATA_WIDTH-1:0] OFF_HI  = DATA_WIDTH'(plan_off_hi(S));
  localparam logic [DATA_WIDTH-1:0] OFF_MID = DATA_WIDTH'(plan_off_mid(S));
  localparam logic [DATA_WIDTH-1:0] OFF_LO  = DATA_WIDTH'(plan_off_lo(S));
  localparam logic [DATA_WIDTH-1:0] MAX_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  // Piecewise-linear approximation of sigmoid on a nonnegative magnitude.
  function automatic logic [DATA_WIDTH-1:0] plan(input logic [DATA_WIDTH-1:0] m);
    if (m >= BP_HI)       return ONE;
    else if (m >= BP_MID) return (m >> 5) + OFF_HI;
    else if (m >= ONE)    return (m >> 3) + OFF_MID;
    else                  return (m >> 2) + OFF_LO;
  endfunction

  logic                  neg;
  logic [DATA_WIDTH-1:0] mag;
  logic [DATA_WIDTH:0]   mag_x2;
  logic [DATA_WIDTH-1:0] mag_t;
  logic [DATA_WIDTH-1:0] p_sig;
  logic [DATA_WIDTH-1:0] p_tanh;
  logic [DATA_WIDTH:0]   t_wide;
  logic [DATA_WIDTH-1:0] t_val;

  always_comb begin
    neg = x[DATA_WIDTH-1];

    // The most negative input has no positive counterpart; clamp it.
    if (x == MIN_NEG)  mag = MAX_POS;
    else if (neg)      mag = DATA_WIDTH'(0) - x;
    else               mag = x;

    // tanh(x) = 2*sigmoid(2x) - 1, with 2x clamped to the positive range.
    mag_x2 = {mag, 1'b0};
    if (mag_x2 > {1'b0, MAX_POS}) mag_t = MAX_POS;
    else                          mag_t = mag_x2[DATA_WIDTH-1:0];

    p_sig  = plan(mag);
    p_tanh = plan(mag_t);
    // p_tanh >= ONE/2, so t is never negative.
    t_wide = {p_tanh, 1'b0} - {1'b0, ONE};
    t_val  = t_wide[DATA_WIDTH-1:0];

    case (sel)
      ACT_NONE:    y = x;
      ACT_RELU:    y = neg ? '0 : x;
      ACT_SIGMOID: y = neg ? (ONE - p_sig) : p_sig;
      ACT_TANH:    y = neg ? (DATA_WIDTH'(0) - t_val) : t_val;
      default:     y = x;
    endcase
  end

endmodule

// File: rtl/activation_unit.sv
// rtl/activation_unit.sv - row-wide registered activation stage
// Ports:
//   clk - rising-edge clock
//   rst - synchronous active-high reset, clears every out lane
//   in  - SA_LENGTH signed lanes from the systolic array
//   sel - function select applied to all lanes (00 id, 01 ReLU, 10 sigmoid, 11 tanh)
//   out - SA_LENGTH registered lane results, one cycle after in/sel
module activation_unit
  import activation_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int SA_LENGTH  = 8,
  parameter int S          = 7
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] in  [SA_LENGTH],
  input  logic [1:0]                   sel,
  output logic signed [DATA_WIDTH-1:0] out [SA_LENGTH]
);

  // 5*ONE must fit in the positive range for PLAN to be overflow-free.
  if (DATA_WIDTH < S + 4) begin : g_width_check
    $error("activation_unit: DATA_WIDTH must be at least S+4");
  end

  act_sel_e                     sel_e;
  logic signed [DATA_WIDTH-1:0] out_d [SA_LENGTH];
  logic signed [DATA_WIDTH-1:0] out_q [SA_LENGTH];

  assign sel_e = act_sel_e'(sel);

  for (genvar i = 0; i < SA_LENGTH; i++) begin : g_lane
    activation_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .S         (S)
    ) u_lane (
      .x  (in[i]),
      .sel(sel_e),
      .y  (out_d[i])
    );
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < SA_LENGTH; i++) begin
      if (rst) out_q[i] <= '0;
      else     out_q[i] <= out_d[i];
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_activation_unit.sv
// tb/tb_activation_unit.sv - self-checking bench for activation_unit
module tb_activation_unit;

  localparam int DW  = 12;
  localparam int N   = 8;
  localparam int S   = 7;
  localparam int ONE = 1 << S;
  localparam int MAXPOS = (1 << (DW - 1)) - 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [1:0]           sel;
  logic signed [DW-1:0] in_v  [N];
  logic signed [DW-1:0] out_v [N];

  int checks = 0;
  int errors = 0;
  int exp_q [N];
  bit exp_valid = 1'b0;

  always #5 clk = ~clk;

  activation_unit #(
    .DATA_WIDTH(DW),
    .SA_LENGTH (N),
    .S         (S)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in (in_v),
    .sel(sel),
    .out(out_v)
  );

  // Reference PLAN: thresholds 5.0, 2.375, 1.0 and slopes 1/32, 1/8, 1/4.
  function automatic int plan(input int m);
    if (m >= 5 * ONE)       return ONE;
    if (8 * m >= 19 * ONE)  return m / 32 + (27 * ONE) / 32;
    if (m >= ONE)           return m / 8 + (5 * ONE) / 8;
    return m / 4 + ONE / 2;
  endfunction

  function automatic int act(input int x, input int s);
    int a, a2, p, t;
    a = (x < 0) ? -x : x;
    if (a > MAXPOS) a = MAXPOS;
    case (s)
      0: return x;
      1: return (x >= 0) ? x : 0;
      2: begin
        p = plan(a);
        return (x >= 0) ? p : ONE - p;
      end
      default: begin
        a2 = (2 * a > MAXPOS) ? MAXPOS : 2 * a;
        t  = 2 * plan(a2) - ONE;
        return (x >= 0) ? t : -t;
      end
    endcase
  endfunction

  // Expected outputs follow the inputs present at each rising edge.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++)
      exp_q[i] = rst ? 0 : act(int'(in_v[i]), int'(sel));
    exp_valid = 1'b1;
  end

  always @(negedge clk) begin
    if (exp_valid) begin
      for (int i = 0; i < N; i++) begin
        checks++;
        if (int'(out_v[i]) != exp_q[i]) begin
          errors++;
          $display("FAIL model lane%0d t=%0t: got %0d expected %0d", i, $time, int'(out_v[i]), exp_q[i]);
        end
      end
    end
  end

  task automatic set_in(input int v [N]);
    for (int i = 0; i < N; i++) in_v[i] = DW'(v[i]);
  endtask

  task automatic check_vec(input string name, input int e [N]);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (int'(out_v[i]) != e[i]) begin
        errors++;
        $display("FAIL %s lane%0d: got %0d expected %0d", name, i, int'(out_v[i]), e[i]);
      end
    end
  endtask

  task automatic check_model(input string name, input int got, input int e);
    checks++;
    if (got != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, e);
    end
  endtask

  int v_main  [N] = '{0, 400, 517, -512, -1, -2048, 2047, 52};
  int v_bnd   [N] = '{127, 128, 303, 304, 639, 640, -128, -640};
  int e_zero  [N] = '{0, 0, 0, 0, 0, 0, 0, 0};
  int e_id    [N] = '{0, 400, 517, -512, -1, -2048, 2047, 52};
  int e_relu  [N] = '{0, 400, 517, 0, 0, 0, 2047, 52};
  int e_sig   [N] = '{64, 120, 124, 4, 64, 0, 128, 77};
  int e_tanh  [N] = '{0, 128, 128, -128, 0, -128, 128, 52};
  int e_bnd   [N] = '{95, 96, 117, 117, 127, 128, 32, 0};

  initial begin
    rst = 1'b1;
    sel = 2'($urandom);
    for (int i = 0; i < N; i++) in_v[i] = DW'($urandom);

    @(negedge clk);
    check_vec("reset", e_zero);

    rst = 1'b0;
    set_in(v_main);
    sel = 2'b00;
    @(negedge clk);
    check_vec("identity", e_id);
    sel = 2'b01;
    @(negedge clk);
    check_vec("relu", e_relu);
    sel = 2'b10;
    @(negedge clk);
    check_vec("sigmoid", e_sig);
    sel = 2'b11;
    @(negedge clk);
    check_vec("tanh", e_tanh);
    sel = 2'b00;
    @(negedge clk);
    check_vec("identity_again", e_id);

    rst = 1'b1;
    sel = 2'b10;
    @(negedge clk);
    check_vec("mid_reset", e_zero);
    rst = 1'b0;
    sel = 2'b11;
    @(negedge clk);
    check_vec("tanh_after_reset", e_tanh);

    set_in(v_bnd);
    sel = 2'b10;
    @(negedge clk);
    check_vec("sigmoid_bounds", e_bnd);

    check_model("model_sig_400", act(400, 2), 120);
    check_model("model_sig_m512", act(-512, 2), 4);
    check_model("model_tanh_52", act(52, 3), 52);
    check_model("model_tanh_m2048", act(-2048, 3), -128);
    check_model("model_relu_m2048", act(-2048, 1), 0);
    check_model("model_sig_303", act(303, 2), 117);

    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 49) == 0);
      sel = 2'($urandom);
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 7))
          0:       in_v[i] = DW'(-2048);
          1:       in_v[i] = DW'(2047);
          2:       in_v[i] = DW'($urandom_range(0, 700));
          3:       in_v[i] = DW'(-int'($urandom_range(0, 700)));
          default: in_v[i] = DW'($urandom);
        endcase
      end
      @(negedge clk);
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
